ifetch_controller: RTL and testbench

Sequences the IF stage. Owns the program counter, drives the combinational instruction-memory address, and captures the returned word into a one-entry output register toward ID using a valid/ready handshake. Accepts branch/jump redirects from later stages with flush, and stops fetching with a fault flag when the PC leaves the populated memory range.

---
 rtl/ifetch_if.sv | 30 +++
 rtl/ifetch_controller.sv | 154 +++++++++++++++
 tb/tb_ifetch_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and the
// valid/ready output toward ID, bundled for the fetch controller.
interface ifetch_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             redirect_valid;
  logic [31:0]      redirect_target;
  logic [31:0]      ins_address;
  logic [31:0]      ins_in;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic             id_ready;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] fetch_count;

  // Environment side: drives control, memory data and ID readiness.
  modport master (
    output start, redirect_valid, redirect_target, ins_in, id_ready,
    input  ins_address, if_valid, if_instr, if_pc, halted, fault, fetch_count
  );

  // Fetch controller side.
  modport slave (
    input  start, redirect_valid, redirect_target, ins_in, id_ready,
    output ins_address, if_valid, if_instr, if_pc, halted, fault, fetch_count
  );
endinterface

// File: rtl/ifetch_controller.sv
// IF-stage sequencer: owns the PC, addresses instruction memory
// combinationally and holds the fetched word in a one-entry register
// toward ID. Redirects flush the held word; fetching past the populated
// range halts the stage with a sticky fault.
module ifetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] PC_STEP    = 32'd4,
  parameter logic [31:0] ADDR_LIMIT = 32'd64,
  parameter int          CNT_W      = 16
) (
  input  logic  clk,
  input  logic  reset,
  ifetch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      pc_q;
  logic             vld_p1;
  logic [31:0]      instr_p1;
  logic [31:0]      pc_p1;
  logic             halted_q;
  logic             fault_q;
  logic [CNT_W-1:0] cnt_q;

  logic load;
  logic restart;
  logic redirect;
  logic fetch;
  logic trap;
  logic accept;

  // Sequential PC advance; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  // Only addresses below the limit are backed by the instruction bank.
  function automatic logic addr_legal(input logic [31:0] addr);
    return (addr < ADDR_LIMIT);
  endfunction

  // Fetch counter wraps naturally at 2^CNT_W.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // The output register may take a new word when empty or being drained.
  assign load = !vld_p1 || bus.id_ready;

  // Next-state and per-cycle action decode; redirect outranks load.
  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    redirect = 1'b0;
    fetch    = 1'b0;
    trap     = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      RUN: begin
        accept = vld_p1 && bus.id_ready && !bus.redirect_valid;
        if (bus.redirect_valid) begin
          redirect = 1'b1;
        end else if (load) begin
          if (addr_legal(pc_q)) begin
            fetch = 1'b1;
          end else begin
            trap    = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (bus.start) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stage p0: program counter driving the memory address.
  always_ff @(posedge clk) begin
    if (reset)         pc_q <= RESET_PC;
    else if (restart)  pc_q <= RESET_PC;
    else if (redirect) pc_q <= bus.redirect_target;
    else if (fetch)    pc_q <= next_pc(pc_q);
  end

  // Stage p1: valid flag of the output register; flushed by redirect or trap.
  always_ff @(posedge clk) begin
    if (reset)                 vld_p1 <= 1'b0;
    else if (redirect || trap) vld_p1 <= 1'b0;
    else if (fetch)            vld_p1 <= 1'b1;
  end

  // Output register payload: captured word and the address it came from.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p1 <= 32'd0;
      pc_p1    <= 32'd0;
    end else if (fetch) begin
      instr_p1 <= bus.ins_in;
      pc_p1    <= pc_q;
    end
  end

  // Halt and sticky fault flags; only reset clears the fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else if (trap) begin
      halted_q <= 1'b1;
      fault_q  <= 1'b1;
    end else if (restart) begin
      halted_q <= 1'b0;
    end
  end

  // Count instructions actually handed to ID.
  always_ff @(posedge clk) begin
    if (reset)       cnt_q <= '0;
    else if (accept) cnt_q <= cnt_inc(cnt_q);
  end

  assign bus.ins_address = pc_q;
  assign bus.if_valid    = vld_p1;
  assign bus.if_instr    = instr_p1;
  assign bus.if_pc       = pc_p1;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_ifetch_controller.sv
// Bench for ifetch_controller: directed scenarios followed by random
// traffic, checked by a scoreboard of expected handed-off instructions
// and a cycle-level reference of the visible fetch-stage state.
module tb_ifetch_controller;
  localparam int CNT_W = 4;
  localparam logic [31:0] LIMIT = 32'd64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_if #(.CNT_W(CNT_W)) bus();

  ifetch_controller #(
    .RESET_PC  (32'd0),
    .PC_STEP   (32'd4),
    .ADDR_LIMIT(LIMIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Instruction memory contents: a scrambled function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign bus.ins_in = mem_word(bus.ins_address);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef enum int {M_IDLE, M_RUN, M_HALT} mode_t;

  exp_t        sb_q[$];
  mode_t       mode;
  logic [31:0] m_pc, m_i, m_p;
  logic        m_v, m_halt, m_fault;
  int          m_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what the fetch stage should look like after one clock.
  task automatic model_step(input logic r, input logic s, input logic rv,
                            input logic [31:0] rt, input logic idr);
    exp_t e;
    if (r) begin
      mode = M_IDLE; m_pc = 32'd0; m_v = 1'b0; m_i = 32'd0; m_p = 32'd0;
      m_halt = 1'b0; m_fault = 1'b0; m_cnt = 0;
      sb_q.delete();
    end else begin
      case (mode)
        M_IDLE: if (s) begin mode = M_RUN; m_pc = 32'd0; end
        M_HALT: if (s) begin mode = M_RUN; m_pc = 32'd0; m_halt = 1'b0; end
        M_RUN: begin
          if (rv) begin
            if (m_v && sb_q.size() > 0) void'(sb_q.pop_front());
            m_v  = 1'b0;
            m_pc = rt;
          end else begin
            if (m_v && idr) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (!m_v || idr) begin
              if (m_pc >= LIMIT) begin
                m_fault = 1'b1; m_halt = 1'b1; m_v = 1'b0; mode = M_HALT;
              end else begin
                m_v = 1'b1; m_p = m_pc; m_i = mem_word(m_pc);
                e.pc = m_pc; e.instr = m_i;
                sb_q.push_back(e);
                m_pc = m_pc + 32'd4;
              end
            end
          end
        end
        default: mode = M_IDLE;
      endcase
    end
  endtask

  // Drive one cycle of inputs, let the clock edge happen, advance the model.
  task automatic cyc(input logic r, input logic s, input logic rv,
                     input logic [31:0] rt, input logic idr);
    reset = r; bus.start = s; bus.redirect_valid = rv;
    bus.redirect_target = rt; bus.id_ready = idr;
    @(posedge clk);
    model_step(r, s, rv, rt, idr);
    #1;
  endtask

  // Monitor: compare visible state and pop the scoreboard on each handoff.
  always @(negedge clk) begin
    exp_t e;
    if (checking) begin
      chk("ins_address", bus.ins_address, m_pc);
      chk("if_valid", {31'd0, bus.if_valid}, {31'd0, m_v});
      chk("if_pc", bus.if_pc, m_p);
      chk("if_instr", bus.if_instr, m_i);
      chk("halted", {31'd0, bus.halted}, {31'd0, m_halt});
      chk("fault", {31'd0, bus.fault}, {31'd0, m_fault});
      chk("fetch_count", {{(32-CNT_W){1'b0}}, bus.fetch_count}, m_cnt);
      if (bus.if_valid === 1'b1 && bus.id_ready && !bus.redirect_valid && !reset) begin
        if (sb_q.size() == 0) begin
          chk("handoff_unexpected", bus.if_pc, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("handoff_pc", bus.if_pc, e.pc);
          chk("handoff_instr", bus.if_instr, e.instr);
        end
      end
    end
  end

  initial begin
    int guard;
    logic [31:0] tgt;
    mode = M_IDLE;
    reset = 1'b1; bus.start = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'd0; bus.id_ready = 1'b0;

    // Reset state
    cyc(1, 0, 0, 0, 0);
    checking = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_addr", bus.ins_address, 32'd0);
    chk("rst_count", {{(32-CNT_W){1'b0}}, bus.fetch_count}, 32'd0);

    // Sequential fetch, then stall with if_pc=8, then release
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk("t1_pc8", bus.if_pc, 32'd8);
    chk("t1_instr8", bus.if_instr, mem_word(32'd8));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    chk("t2_addr_hold", bus.ins_address, 32'd12);
    chk("t2_pc_hold", bus.if_pc, 32'd8);
    cyc(0, 0, 0, 0, 1);
    chk("t2_pc12", bus.if_pc, 32'd12);
    chk("t1_count3", {{(32-CNT_W){1'b0}}, bus.fetch_count}, 32'd3);

    // Redirect while if_pc=4 is presented with id_ready=1
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t3_pc4", bus.if_pc, 32'd4);
    cyc(0, 0, 1, 32'd24, 1);
    chk("t3_bubble", {31'd0, bus.if_valid}, 32'd0);
    chk("t3_count", {{(32-CNT_W){1'b0}}, bus.fetch_count}, 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t3_pc24", bus.if_pc, 32'd24);
    chk("t3_instr24", bus.if_instr, mem_word(32'd24));

    // Run off the end of the bank
    guard = 0;
    while (bus.halted !== 1'b1 && guard < 40) begin
      cyc(0, 0, 0, 0, 1);
      guard++;
    end
    chk("t4_halt_reached", {31'd0, bus.halted}, 32'd1);
    chk("t4_fault", {31'd0, bus.fault}, 32'd1);
    chk("t4_valid", {31'd0, bus.if_valid}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'd8, 1);
    chk("t4_redirect_ignored", bus.ins_address, 32'd64);
    cyc(0, 1, 0, 0, 1);
    chk("t4_restart_halted", {31'd0, bus.halted}, 32'd0);
    chk("t4_fault_sticky", {31'd0, bus.fault}, 32'd1);
    chk("t4_restart_addr", bus.ins_address, 32'd0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Reset while stalled holding a valid word
    cyc(0, 0, 0, 0, 0);
    chk("t5_held", {31'd0, bus.if_valid}, 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("t5_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("t5_fault", {31'd0, bus.fault}, 32'd0);
    chk("t5_pc", bus.if_pc, 32'd0);
    chk("t5_instr", bus.if_instr, 32'd0);
    cyc(0, 0, 0, 0, 1);
    chk("t5_idle_nofetch", {31'd0, bus.if_valid}, 32'd0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t5_pc0", bus.if_pc, 32'd0);

    // Redirect together with stall
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'd36, 0);
    chk("t6_flush", {31'd0, bus.if_valid}, 32'd0);
    chk("t6_addr", bus.ins_address, 32'd36);
    cyc(0, 0, 0, 0, 0);
    chk("t6_pc36", bus.if_pc, 32'd36);
    chk("t6_instr36", bus.if_instr, mem_word(32'd36));

    // Random traffic, including counter wrap and out-of-range redirects
    for (int i = 0; i < 4000; i++) begin
      tgt = 32'($urandom_range(0, 20)) * 32'd4;
      cyc(($urandom % 200) == 0, ($urandom % 20) == 0, ($urandom % 10) == 0,
          tgt, ($urandom % 4) != 0);
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
